// File: rtl/escalonador_contexto_if.sv
// Preemption handshake between Program_Counter (master) and the context scheduler (slave).
interface escalonador_contexto_if #(
    parameter int unsigned PC_W = 32
);
    logic            flag_faz_preempcao;
    logic [PC_W-1:0] salva_PC;
    logic            halt_cpu;
    logic            carrega_PC;
    logic [PC_W-1:0] novo_PC;
    logic            reset_cont_preempcao;

    modport master (
        output flag_faz_preempcao,
        output salva_PC,
        input  halt_cpu,
        input  carrega_PC,
        input  novo_PC,
        input  reset_cont_preempcao
    );

    modport slave (
        input  flag_faz_preempcao,
        input  salva_PC,
        output halt_cpu,
        output carrega_PC,
        output novo_PC,
        output reset_cont_preempcao
    );
endinterface

// File: rtl/escalonador_contexto.sv
// Context scheduler: saves the preempted PC, picks the next ready process round-robin
// and reloads the PC, stalling the CPU while the switch is in progress.
module escalonador_contexto #(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned PC_W     = 32
) (
    input  logic                 clock,
    input  logic                 reset_geral,
    input  logic                 modo_preemptivo,
    input  logic                 cria_proc,
    input  logic [IDW-1:0]       cria_id,
    input  logic [PC_W-1:0]      cria_PC,
    input  logic                 mata_proc,
    output logic [IDW-1:0]       proc_atual,
    output logic                 ocupado,
    escalonador_contexto_if.slave preempcao
);

    typedef enum logic [2:0] {
        OCIOSO,
        EXEC,
        SALVA,
        BUSCA,
        CARREGA,
        LIBERA
    } estado_t;

    estado_t         r_estado;
    logic [NUM_PROC-1:0] r_valid;
    logic [PC_W-1:0] r_table_pc [NUM_PROC];
    logic [IDW-1:0]  r_proc_atual;
    logic            r_halt_cpu;
    logic            r_carrega_pc;
    logic [PC_W-1:0] r_novo_pc;
    logic            r_reset_cont;
    logic            r_ocupado;

    logic            w_found;
    logic [IDW-1:0]  w_next_id;
    logic [IDW-1:0]  w_cand;

    // Round-robin scan: walk offsets downwards so the smallest offset after proc_atual wins;
    // offset NUM_PROC wraps to the current id, making it the last candidate.
    always_comb begin
        w_found   = 1'b0;
        w_next_id = r_proc_atual;
        w_cand    = r_proc_atual;
        for (int i = int'(NUM_PROC); i >= 1; i--) begin
            w_cand = r_proc_atual + IDW'(i);
            if (r_valid[w_cand]) begin
                w_found   = 1'b1;
                w_next_id = w_cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_geral) begin
            r_estado     <= OCIOSO;
            r_valid      <= '0;
            r_proc_atual <= '0;
            r_halt_cpu   <= 1'b1;
            r_carrega_pc <= 1'b0;
            r_novo_pc    <= '0;
            r_reset_cont <= 1'b0;
            r_ocupado    <= 1'b0;
            for (int i = 0; i < int'(NUM_PROC); i++) begin
                r_table_pc[i] <= '0;
            end
        end else begin
            r_carrega_pc <= 1'b0;
            r_reset_cont <= 1'b0;

            // Creation never overwrites a live context; a later SALVA write below takes precedence.
            if (cria_proc && !r_valid[cria_id]) begin
                r_valid[cria_id]    <= 1'b1;
                r_table_pc[cria_id] <= cria_PC;
            end

            case (r_estado)
                OCIOSO: begin
                    r_halt_cpu <= 1'b1;
                    if (cria_proc) begin
                        r_estado  <= BUSCA;
                        r_ocupado <= 1'b1;
                    end
                end
                EXEC: begin
                    if (mata_proc) begin
                        r_valid[r_proc_atual] <= 1'b0;
                        r_halt_cpu            <= 1'b1;
                        r_ocupado             <= 1'b1;
                        r_estado              <= BUSCA;
                    end else if (preempcao.flag_faz_preempcao && modo_preemptivo) begin
                        r_halt_cpu <= 1'b1;
                        r_ocupado  <= 1'b1;
                        r_estado   <= SALVA;
                    end
                end
                SALVA: begin
                    r_table_pc[r_proc_atual] <= preempcao.salva_PC;
                    r_estado                 <= BUSCA;
                end
                BUSCA: begin
                    if (w_found) begin
                        r_proc_atual <= w_next_id;
                        r_carrega_pc <= 1'b1;
                        r_novo_pc    <= r_table_pc[w_next_id];
                        r_estado     <= CARREGA;
                    end else begin
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                end
                CARREGA: begin
                    r_reset_cont <= 1'b1;
                    r_estado     <= LIBERA;
                end
                LIBERA: begin
                    r_halt_cpu <= 1'b0;
                    r_ocupado  <= 1'b0;
                    r_estado   <= EXEC;
                end
                default: begin
                    r_halt_cpu <= 1'b1;
                    r_ocupado  <= 1'b0;
                    r_estado   <= OCIOSO;
                end
            endcase
        end
    end

    assign preempcao.halt_cpu             = r_halt_cpu;
    assign preempcao.carrega_PC           = r_carrega_pc;
    assign preempcao.novo_PC              = r_novo_pc;
    assign preempcao.reset_cont_preempcao = r_reset_cont;
    assign proc_atual                     = r_proc_atual;
    assign ocupado                        = r_ocupado;

endmodule

// File: tb/tb_escalonador_contexto.sv
// Directed bench for escalonador_contexto: creation, round-robin preemption, kill, mode-off and reset.
module tb_escalonador_contexto;

    logic        clock = 1'b0;
    logic        reset_geral = 1'b1;
    logic        modo_preemptivo = 1'b1;
    logic        cria_proc = 1'b0;
    logic [1:0]  cria_id = '0;
    logic [31:0] cria_PC = '0;
    logic        mata_proc = 1'b0;
    logic [1:0]  proc_atual;
    logic        ocupado;

    int errors = 0;
    int checks = 0;

    escalonador_contexto_if #(.PC_W(32)) u_if ();

    escalonador_contexto #(.NUM_PROC(4), .IDW(2), .PC_W(32)) u_dut (
        .clock           (clock),
        .reset_geral     (reset_geral),
        .modo_preemptivo (modo_preemptivo),
        .cria_proc       (cria_proc),
        .cria_id         (cria_id),
        .cria_PC         (cria_PC),
        .mata_proc       (mata_proc),
        .proc_atual      (proc_atual),
        .ocupado         (ocupado),
        .preempcao       (u_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_geral = 1'b1;
        u_if.flag_faz_preempcao = 1'b0;
        u_if.salva_PC = '0;
        cria_proc = 1'b0;
        mata_proc = 1'b0;
        tick();
        tick();
        checks++; if (u_if.halt_cpu !== 1'b1) begin errors++; $display("FAIL reset_halt got=%b exp=1", u_if.halt_cpu); end
        checks++; if (u_if.carrega_PC !== 1'b0) begin errors++; $display("FAIL reset_carrega got=%b exp=0", u_if.carrega_PC); end
        checks++; if (u_if.novo_PC !== 32'h0) begin errors++; $display("FAIL reset_novo got=%h exp=0", u_if.novo_PC); end
        checks++; if (u_if.reset_cont_preempcao !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", u_if.reset_cont_preempcao); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
        checks++; if (proc_atual !== 2'd0) begin errors++; $display("FAIL reset_proc got=%0d exp=0", proc_atual); end
        reset_geral = 1'b0;
        tick();
    endtask

    // Create a process while idle and follow it through BUSCA/CARREGA/LIBERA into EXEC.
    task automatic start_from_idle(input logic [1:0] id, input logic [31:0] pc, input string tag);
        cria_id = id; cria_PC = pc; cria_proc = 1'b1;
        tick();
        cria_proc = 1'b0;
        checks++; if (ocupado !== 1'b1 || u_if.halt_cpu !== 1'b1 || u_if.carrega_PC !== 1'b0) begin
            errors++; $display("FAIL %s_busca ocupado=%b halt=%b carrega=%b exp 1,1,0", tag, ocupado, u_if.halt_cpu, u_if.carrega_PC); end
        tick();
        checks++; if (u_if.carrega_PC !== 1'b1 || u_if.novo_PC !== pc || proc_atual !== id) begin
            errors++; $display("FAIL %s_carrega carrega=%b novo=%h proc=%0d exp 1,%h,%0d", tag, u_if.carrega_PC, u_if.novo_PC, proc_atual, pc, id); end
        tick();
        checks++; if (u_if.reset_cont_preempcao !== 1'b1 || u_if.carrega_PC !== 1'b0 || u_if.halt_cpu !== 1'b1) begin
            errors++; $display("FAIL %s_libera ack=%b carrega=%b halt=%b exp 1,0,1", tag, u_if.reset_cont_preempcao, u_if.carrega_PC, u_if.halt_cpu); end
        tick();
        checks++; if (u_if.halt_cpu !== 1'b0 || u_if.reset_cont_preempcao !== 1'b0 || ocupado !== 1'b0 || u_if.novo_PC !== pc) begin
            errors++; $display("FAIL %s_exec halt=%b ack=%b ocupado=%b novo=%h exp 0,0,0,%h", tag, u_if.halt_cpu, u_if.reset_cont_preempcao, ocupado, u_if.novo_PC, pc); end
    endtask

    // Full preemption from EXEC with fixed latency: SALVA, BUSCA, CARREGA, LIBERA, EXEC.
    task automatic preempt(input logic [31:0] salva, input logic [31:0] exp_pc, input logic [1:0] exp_id, input string tag);
        u_if.flag_faz_preempcao = 1'b1;
        u_if.salva_PC = salva;
        tick();
        checks++; if (u_if.halt_cpu !== 1'b1 || ocupado !== 1'b1) begin
            errors++; $display("FAIL %s_salva halt=%b ocupado=%b exp 1,1", tag, u_if.halt_cpu, ocupado); end
        tick();
        checks++; if (u_if.carrega_PC !== 1'b0) begin
            errors++; $display("FAIL %s_busca carrega=%b exp 0", tag, u_if.carrega_PC); end
        tick();
        checks++; if (u_if.carrega_PC !== 1'b1 || u_if.novo_PC !== exp_pc || proc_atual !== exp_id || u_if.reset_cont_preempcao !== 1'b0) begin
            errors++; $display("FAIL %s_carrega carrega=%b novo=%h proc=%0d ack=%b exp 1,%h,%0d,0", tag, u_if.carrega_PC, u_if.novo_PC, proc_atual, u_if.reset_cont_preempcao, exp_pc, exp_id); end
        tick();
        checks++; if (u_if.reset_cont_preempcao !== 1'b1 || u_if.carrega_PC !== 1'b0 || u_if.halt_cpu !== 1'b1) begin
            errors++; $display("FAIL %s_ack ack=%b carrega=%b halt=%b exp 1,0,1", tag, u_if.reset_cont_preempcao, u_if.carrega_PC, u_if.halt_cpu); end
        u_if.flag_faz_preempcao = 1'b0;
        tick();
        checks++; if (u_if.halt_cpu !== 1'b0 || u_if.reset_cont_preempcao !== 1'b0 || ocupado !== 1'b0 || u_if.novo_PC !== exp_pc) begin
            errors++; $display("FAIL %s_exec halt=%b ack=%b ocupado=%b novo=%h exp 0,0,0,%h", tag, u_if.halt_cpu, u_if.reset_cont_preempcao, ocupado, u_if.novo_PC, exp_pc); end
    endtask

    task automatic pulse_cria(input logic [1:0] id, input logic [31:0] pc);
        cria_id = id; cria_PC = pc; cria_proc = 1'b1;
        tick();
        cria_proc = 1'b0;
    endtask

    task automatic test_first_process();
        start_from_idle(2'd0, 32'h10, "first");
    endtask

    task automatic test_round_robin();
        pulse_cria(2'd1, 32'h20);
        pulse_cria(2'd2, 32'h30);
        checks++; if (u_if.halt_cpu !== 1'b0 || proc_atual !== 2'd0) begin
            errors++; $display("FAIL rr_create_in_exec halt=%b proc=%0d exp 0,0", u_if.halt_cpu, proc_atual); end
        preempt(32'h15, 32'h20, 2'd1, "rr_0to1");
        preempt(32'h25, 32'h30, 2'd2, "rr_1to2");
        preempt(32'h35, 32'h15, 2'd0, "rr_wrap");
    endtask

    task automatic test_single_process();
        start_from_idle(2'd3, 32'h40, "single_start");
        preempt(32'h44, 32'h44, 2'd3, "single_repick");
    endtask

    task automatic test_mata_idle();
        mata_proc = 1'b1;
        tick();
        mata_proc = 1'b0;
        checks++; if (u_if.halt_cpu !== 1'b1 || ocupado !== 1'b1) begin
            errors++; $display("FAIL mata_busca halt=%b ocupado=%b exp 1,1", u_if.halt_cpu, ocupado); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (u_if.halt_cpu !== 1'b1 || ocupado !== 1'b0 || u_if.carrega_PC !== 1'b0) begin
                errors++; $display("FAIL mata_idle%0d halt=%b ocupado=%b carrega=%b exp 1,0,0", i, u_if.halt_cpu, ocupado, u_if.carrega_PC); end
        end
        start_from_idle(2'd2, 32'h80, "mata_resume");
    endtask

    task automatic test_modo_off();
        modo_preemptivo = 1'b0;
        u_if.flag_faz_preempcao = 1'b1;
        u_if.salva_PC = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (u_if.halt_cpu !== 1'b0 || u_if.reset_cont_preempcao !== 1'b0 || ocupado !== 1'b0 || u_if.carrega_PC !== 1'b0) begin
                errors++; $display("FAIL modo_off%0d halt=%b ack=%b ocupado=%b carrega=%b exp 0,0,0,0", i, u_if.halt_cpu, u_if.reset_cont_preempcao, ocupado, u_if.carrega_PC); end
        end
        u_if.flag_faz_preempcao = 1'b0;
        modo_preemptivo = 1'b1;
        pulse_cria(2'd0, 32'h50);
        pulse_cria(2'd0, 32'h66);
        pulse_cria(2'd2, 32'h99);
        preempt(32'h88, 32'h50, 2'd0, "no_overwrite_0");
        preempt(32'h51, 32'h88, 2'd2, "no_overwrite_2");
    endtask

    task automatic test_mata_priority();
        mata_proc = 1'b1;
        u_if.flag_faz_preempcao = 1'b1;
        u_if.salva_PC = 32'hBAD0;
        tick();
        mata_proc = 1'b0;
        u_if.flag_faz_preempcao = 1'b0;
        checks++; if (u_if.halt_cpu !== 1'b1 || ocupado !== 1'b1) begin
            errors++; $display("FAIL prio_busca halt=%b ocupado=%b exp 1,1", u_if.halt_cpu, ocupado); end
        tick();
        checks++; if (u_if.carrega_PC !== 1'b1 || u_if.novo_PC !== 32'h51 || proc_atual !== 2'd0) begin
            errors++; $display("FAIL prio_carrega carrega=%b novo=%h proc=%0d exp 1,51,0", u_if.carrega_PC, u_if.novo_PC, proc_atual); end
        tick();
        tick();
        checks++; if (u_if.halt_cpu !== 1'b0) begin
            errors++; $display("FAIL prio_exec halt=%b exp 0", u_if.halt_cpu); end
    endtask

    task automatic test_reset_in_carrega();
        u_if.flag_faz_preempcao = 1'b1;
        u_if.salva_PC = 32'h90;
        tick();
        tick();
        tick();
        checks++; if (u_if.carrega_PC !== 1'b1 || u_if.novo_PC !== 32'h90 || proc_atual !== 2'd0) begin
            errors++; $display("FAIL rc_carrega carrega=%b novo=%h proc=%0d exp 1,90,0", u_if.carrega_PC, u_if.novo_PC, proc_atual); end
        reset_geral = 1'b1;
        u_if.flag_faz_preempcao = 1'b0;
        tick();
        checks++; if (u_if.halt_cpu !== 1'b1 || u_if.carrega_PC !== 1'b0 || u_if.novo_PC !== 32'h0 ||
                      u_if.reset_cont_preempcao !== 1'b0 || ocupado !== 1'b0 || proc_atual !== 2'd0) begin
            errors++; $display("FAIL rc_reset halt=%b carrega=%b novo=%h ack=%b ocupado=%b proc=%0d exp 1,0,0,0,0,0",
                u_if.halt_cpu, u_if.carrega_PC, u_if.novo_PC, u_if.reset_cont_preempcao, ocupado, proc_atual); end
        reset_geral = 1'b0;
        mata_proc = 1'b1;
        u_if.flag_faz_preempcao = 1'b1;
        tick();
        mata_proc = 1'b0;
        u_if.flag_faz_preempcao = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (u_if.halt_cpu !== 1'b1 || ocupado !== 1'b0 || u_if.carrega_PC !== 1'b0) begin
                errors++; $display("FAIL rc_empty%0d halt=%b ocupado=%b carrega=%b exp 1,0,0", i, u_if.halt_cpu, ocupado, u_if.carrega_PC); end
        end
        start_from_idle(2'd1, 32'h70, "rc_restart");
    endtask

    initial begin
        u_if.flag_faz_preempcao = 1'b0;
        u_if.salva_PC = '0;
        test_reset();
        test_first_process();
        test_round_robin();
        test_reset();
        test_single_process();
        test_mata_idle();
        test_modo_off();
        test_mata_priority();
        test_reset_in_carrega();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
